// File: rtl/dmem_stall_adapter.sv
// M-stage load/store to req/ack data-memory bus adapter; stalls the pipeline while a bus transaction is outstanding.
// Optional DMEM_TIMEOUT_EN: abort a transaction that waits TIMEOUT cycles for bus_ack and raise sticky bus_err.
module dmem_stall_adapter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_m,
  input  logic              dmem_write_m,
  input  logic [ADDR_W-1:0] addr_m,
  input  logic [DATA_W-1:0] wdata_m,
  output logic [DATA_W-1:0] rdata_m,
  output logic              stall_m,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("dmem_stall_adapter: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              stall;
  logic              req_m;

  assign req_m = mem_read_m | dmem_write_m;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    stall       = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        stall = req_m;
        if (req_m) begin
          bus_addr_d  = addr_m;
          bus_wdata_d = wdata_m;
          bus_we_d    = dmem_write_m;  // write wins when both are asserted
          bus_req_d   = 1'b1;
          state_d     = REQ;
`ifdef DMEM_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) rdata_d = bus_rdata;
          state_d   = DONE;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          if (!bus_we_q) rdata_d = '0;
          state_d   = DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      // Instruction still sits in M this cycle; ignore req_m so it is not reissued.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign stall_m   = reset ? 1'b0 : stall;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign rdata_m   = rdata_q;
`ifdef DMEM_TIMEOUT_EN
  assign bus_err   = err_q;
`else
  assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_stall_adapter.sv
// Directed-vector bench for dmem_stall_adapter; expected values are hand-computed per cycle.
module tb_dmem_stall_adapter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef DMEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_read_m, dmem_write_m;
  logic [AW-1:0] addr_m;
  logic [DW-1:0] wdata_m;
  logic [DW-1:0] rdata_m;
  logic          stall_m, bus_req, bus_we, bus_ack, bus_err;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;

  int vecs = 0;
  int miss = 0;

  dmem_stall_adapter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .mem_read_m(mem_read_m), .dmem_write_m(dmem_write_m),
    .addr_m(addr_m), .wdata_m(wdata_m), .rdata_m(rdata_m), .stall_m(stall_m),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_read_m = 1'b0; dmem_write_m = 1'b0;
    addr_m = '0; wdata_m = '0; bus_ack = 1'b0; bus_rdata = '0;
    tick(); tick();
    mem_read_m = 1'b1; settle();
    chk("rst_stall", stall_m, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_we", bus_we, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_rdata", rdata_m, 0);
    chk("rst_err", bus_err, 0);
    mem_read_m = 1'b0; reset = 1'b0;
    tick();

    // Load, zero-wait
    mem_read_m = 1'b1; addr_m = 32'h40; settle();
    chk("ld0_idle_stall", stall_m, 1);
    chk("ld0_idle_req", bus_req, 0);
    tick();
    chk("ld0_req", bus_req, 1);
    chk("ld0_we", bus_we, 0);
    chk("ld0_addr", bus_addr, 32'h40);
    chk("ld0_stall", stall_m, 1);
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    tick();
    bus_ack = 1'b0; bus_rdata = '0; settle();
    chk("ld0_done_req", bus_req, 0);
    chk("ld0_done_stall", stall_m, 0);
    chk("ld0_rdata", rdata_m, 32'hCAFE_F00D);
    tick();
    mem_read_m = 1'b0; settle();
    chk("ld0_after_stall", stall_m, 0);
    tick();
    chk("ld0_no_2nd_req", bus_req, 0);

    // Store with 3 wait cycles
    dmem_write_m = 1'b1; addr_m = 32'h80; wdata_m = 32'h1234_5678; settle();
    chk("st3_idle_stall", stall_m, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("st3_req_c%0d", i), bus_req, 1);
      chk($sformatf("st3_we_c%0d", i), bus_we, 1);
      chk($sformatf("st3_wdata_c%0d", i), bus_wdata, 32'h1234_5678);
      chk($sformatf("st3_addr_c%0d", i), bus_addr, 32'h80);
      chk($sformatf("st3_stall_c%0d", i), stall_m, 1);
      if (i == 3) begin bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF; end
      tick();
    end
    bus_ack = 1'b0; settle();
    chk("st3_done_req", bus_req, 0);
    chk("st3_done_stall", stall_m, 0);
    chk("st3_rdata_kept", rdata_m, 32'hCAFE_F00D);
    tick();
    dmem_write_m = 1'b0; settle();

    // Back-to-back load then store
    mem_read_m = 1'b1; addr_m = 32'h10; settle();
    tick();
    chk("b2b_ld_req", bus_req, 1);
    bus_ack = 1'b1; bus_rdata = 32'hA;
    tick();
    bus_ack = 1'b0; bus_rdata = '0;
    mem_read_m = 1'b0; dmem_write_m = 1'b1; addr_m = 32'h14; wdata_m = 32'h55; settle();
    chk("b2b_ld_rdata", rdata_m, 32'hA);
    chk("b2b_done_req", bus_req, 0);
    chk("b2b_done_stall", stall_m, 0);
    tick();
    chk("b2b_idle_req", bus_req, 0);
    chk("b2b_idle_stall", stall_m, 1);
    tick();
    chk("b2b_st_req", bus_req, 1);
    chk("b2b_st_addr", bus_addr, 32'h14);
    chk("b2b_st_we", bus_we, 1);
    chk("b2b_rdata_hold", rdata_m, 32'hA);
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    tick();
    bus_ack = 1'b0; settle();
    chk("b2b_st_rdata", rdata_m, 32'hA);
    tick();
    dmem_write_m = 1'b0; settle();

    // Spurious ack with no request
    bus_ack = 1'b1; bus_rdata = 32'h1111_2222; settle();
    chk("spur_stall", stall_m, 0);
    tick();
    bus_ack = 1'b0; settle();
    chk("spur_req", bus_req, 0);
    chk("spur_rdata", rdata_m, 32'hA);
    chk("spur_err", bus_err, 0);
    chk("spur_stall2", stall_m, 0);

    // Reset in the 2nd REQ cycle, ack one cycle later
    mem_read_m = 1'b1; addr_m = 32'h20; settle();
    tick();
    chk("rmid_req1", bus_req, 1);
    tick();
    chk("rmid_req2", bus_req, 1);
    reset = 1'b1; settle();
    chk("rmid_stall_in_rst", stall_m, 0);
    tick();
    reset = 1'b0; mem_read_m = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h7777_7777; settle();
    chk("rmid_req_off", bus_req, 0);
    chk("rmid_rdata", rdata_m, 0);
    chk("rmid_stall", stall_m, 0);
    tick();
    bus_ack = 1'b0; settle();
    chk("rmid_ack_ign_req", bus_req, 0);
    chk("rmid_ack_ign_rdata", rdata_m, 0);
    chk("rmid_ack_ign_stall", stall_m, 0);

`ifdef DMEM_TIMEOUT_EN
    // Timeout on a load with no ack
    mem_read_m = 1'b1; addr_m = 32'h30; settle();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tmo_req_c%0d", i), bus_req, 1);
      chk($sformatf("tmo_err_c%0d", i), bus_err, 0);
      tick();
    end
    chk("tmo_req_drop", bus_req, 0);
    chk("tmo_err", bus_err, 1);
    chk("tmo_rdata", rdata_m, 0);
    chk("tmo_stall", stall_m, 0);
    tick();
    mem_read_m = 1'b0; dmem_write_m = 1'b1; addr_m = 32'h34; settle();
    tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0; dmem_write_m = 1'b0; settle();
    chk("tmo_err_sticky", bus_err, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; settle();
    chk("tmo_err_clr", bus_err, 0);
`else
    chk("err_tied", bus_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
